// File: rtl/multicycle_program_loader.sv
// rtl/multicycle_program_loader.sv - byte-stream program loader writing 32-bit words with XOR checksum check
module multicycle_program_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wd,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error,
   output logic [2:0]            state
);

   localparam int WORD_BITS = ADDR_WIDTH - 2;
   // Capacity in words, held in 9 bits so a count of 64 fits and 65 compares larger.
   localparam logic [8:0] CAPACITY = 9'(2 ** (ADDR_WIDTH - 2));

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DATA  = 3'd1,
      S_WRITE = 3'd2,
      S_CHECK = 3'd3,
      S_RUN   = 3'd4,
      S_ERROR = 3'd5
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [7:0]            count;
   logic [WORD_BITS-1:0]  word_idx;
   logic [1:0]            byte_idx;
   logic [7:0]            xor_acc;
   logic [23:0]           word;     // lower three bytes; the top byte goes straight to mem_wd
   logic                  xfer;
   logic                  count_bad;
   logic                  last_word;

   // Every output is a decode of the registered state, so cpu_reset cannot glitch.
   assign in_ready  = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_CHECK);
   assign mem_we    = (state_q == S_WRITE);
   assign done      = (state_q == S_RUN);
   assign error     = (state_q == S_ERROR);
   assign cpu_reset = (state_q != S_RUN);
   assign state     = state_q;

   assign xfer      = in_valid && in_ready;
   assign count_bad = (in_data == 8'd0) || ({1'b0, in_data} > CAPACITY);
   assign last_word = (9'(word_idx) + 9'd1) == {1'b0, count};

   // State register; reset wins over any transfer on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; RUN and ERROR are terminal until reset.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (xfer) state_d = count_bad ? S_ERROR : S_DATA;
         S_DATA:  if (xfer && (byte_idx == 2'd3)) state_d = S_WRITE;
         S_WRITE: state_d = last_word ? S_CHECK : S_DATA;
         S_CHECK: if (xfer) state_d = (in_data == xor_acc) ? S_RUN : S_ERROR;
         S_RUN:   state_d = S_RUN;
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: count latch, byte assembly, checksum, and the registered write port.
   always_ff @(posedge clock) begin
      if (reset) begin
         count    <= 8'd0;
         word_idx <= '0;
         byte_idx <= 2'd0;
         xor_acc  <= 8'd0;
         word     <= 24'd0;
         mem_addr <= '0;
         mem_wd   <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (xfer) begin
                  count    <= in_data;
                  word_idx <= '0;
                  byte_idx <= 2'd0;
                  xor_acc  <= 8'd0;
               end
            end
            S_DATA: begin
               if (xfer) begin
                  xor_acc  <= xor_acc ^ in_data;
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: word[7:0]   <= in_data;
                     2'd1: word[15:8]  <= in_data;
                     2'd2: word[23:16] <= in_data;
                     default: begin
                        // Stage the whole word for the WRITE cycle; it then holds until the next word.
                        mem_wd   <= {in_data, word};
                        mem_addr <= {word_idx, 2'b00};
                     end
                  endcase
               end
            end
            S_WRITE: begin
               word_idx <= word_idx + WORD_BITS'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule
